// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory behind a request/response handshake with a fixed
// number of wait states per access. Supports RISC-V load/store sizes and signs,
// and flags misaligned, out-of-range and illegal-funct3 accesses as faults.
module data_mem_ctrl #(
    parameter int BYTES = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        resp_entry;

    // Request fields captured on accept
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // The access being resolved: live inputs in IDLE (zero-wait case), latched otherwise
    logic        acc_we;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_size;
    logic        legal;
    logic        fault;
    logic [32:0] last_byte;
    logic        mem_wr;

    logic [AW-1:0] lane_idx [4];
    logic [7:0]    lane_rd  [4];
    logic [31:0]   raw_word;
    logic [31:0]   load_val;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q;

    // Storage starts zeroed and is deliberately left out of reset
    logic [7:0] mem_q [BYTES] = '{default: 8'h00};

    // State register and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count WAIT cycles, one-cycle RESP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        resp_entry = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = 4'd0;
                    if (WAIT == 0) begin
                        state_d    = S_RESP;
                        resp_entry = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT - 1)) begin
                    state_d    = S_RESP;
                    resp_entry = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request fields on the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_f3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign acc_f3    = (state_q == S_IDLE) ? req_f3    : f3_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    // Decode access size and fault conditions
    always_comb begin
        case (acc_f3[1:0])
            2'd0:    acc_size = 3'd1;
            2'd1:    acc_size = 3'd2;
            2'd2:    acc_size = 3'd4;
            default: acc_size = 3'd0;
        endcase
        legal = acc_we ? (acc_f3 inside {3'd0, 3'd1, 3'd2})
                       : (acc_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        last_byte = {1'b0, acc_addr} + 33'(acc_size) - 33'd1;
        fault = !legal
              || (acc_size == 3'd2 && acc_addr[0])
              || (acc_size == 3'd4 && acc_addr[1:0] != 2'b00)
              || (last_byte >= 33'(BYTES));
    end

    // Four byte lanes, little-endian from the access address
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_idx[gi] = acc_addr[AW-1:0] + AW'(gi);
        assign lane_rd[gi]  = mem_q[lane_idx[gi]];
    end

    assign raw_word = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};

    // Size and sign handling for loads; stores and faults return zero
    always_comb begin
        case (acc_f3)
            3'b000:  load_val = {{24{raw_word[7]}}, raw_word[7:0]};
            3'b001:  load_val = {{16{raw_word[15]}}, raw_word[15:0]};
            3'b010:  load_val = raw_word;
            3'b100:  load_val = {24'd0, raw_word[7:0]};
            3'b101:  load_val = {16'd0, raw_word[15:0]};
            default: load_val = 32'd0;
        endcase
        rdata_d = (fault || acc_we) ? 32'd0 : load_val;
    end

    // Response data/error are captured on RESP entry and held until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (resp_entry) begin
            rdata_q <= rdata_d;
            err_q   <= fault;
        end
    end

    // Gate with rst so a zero-wait accept cannot write while reset is held
    assign mem_wr = rst && resp_entry && acc_we && !fault;

    // Store commit on RESP entry, only the lanes covered by the access size
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_wr && (k < int'(acc_size))) begin
                mem_q[lane_idx[k]] <= acc_wdata[8*k +: 8];
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance 0 uses WAIT=2, instance 1 uses WAIT=0.
// A transaction-level model predicts ready/valid/rdata/err every cycle; directed
// sequences add literal expectations, then both instances get random traffic.
module tb_data_mem_ctrl;
    localparam int BYTES = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    data_mem_ctrl #(.BYTES(BYTES), .WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_f3(req_f3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.BYTES(BYTES), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_f3(req_f3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned mem_m  [2][BYTES];
    bit           m_pend [2];
    int           m_left [2];   // cycles until the response cycle
    bit           m_we   [2];
    bit [2:0]     m_f3   [2];
    bit [31:0]    m_addr [2];
    bit [31:0]    m_wdata[2];
    bit [31:0]    m_rdata[2];
    bit           m_err  [2];

    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Resolve one access against the model memory
    task automatic model_exec(input int i);
        int     size;
        bit     legal;
        bit     err;
        longint val;
        case (m_f3[i][1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal = m_we[i] ? (m_f3[i] <= 3'd2) : (m_f3[i] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal || (size == 2 && m_addr[i] % 2 != 0) || (size == 4 && m_addr[i] % 4 != 0)
              || (longint'(m_addr[i]) + size - 1 >= BYTES);
        m_err[i]   = err;
        m_rdata[i] = 32'd0;
        if (!err) begin
            if (m_we[i]) begin
                for (int k = 0; k < size; k++)
                    mem_m[i][m_addr[i] + k] = 8'(m_wdata[i] >> (8 * k));
            end else begin
                val = 0;
                for (int k = 0; k < size; k++)
                    val += longint'(mem_m[i][m_addr[i] + k]) << (8 * k);
                if (m_f3[i][2] == 1'b0 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                    val -= (longint'(1) << (8 * size));
                m_rdata[i] = 32'(val);
            end
        end
    endtask

    // Compare, then advance the model to what the next rising edge produces
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                m_pend[i]  = 1'b0;
                m_left[i]  = 0;
                m_rdata[i] = 32'd0;
                m_err[i]   = 1'b0;
            end
            chk($sformatf("ready[%0d] cyc %0d", i, cyc), req_ready[i], !m_pend[i]);
            chk($sformatf("valid[%0d] cyc %0d", i, cyc), rsp_valid[i], m_pend[i] && m_left[i] == 0);
            chk($sformatf("rdata[%0d] cyc %0d", i, cyc), rsp_rdata[i], m_rdata[i]);
            if (!rst[i] || (m_pend[i] && m_left[i] == 0))
                chk($sformatf("err[%0d] cyc %0d", i, cyc), rsp_err[i], m_err[i]);
            if (rst[i]) begin
                if (m_pend[i]) begin
                    if (m_left[i] == 0) begin
                        m_pend[i] = 1'b0;
                    end else begin
                        m_left[i]--;
                        if (m_left[i] == 0) model_exec(i);
                    end
                end else if (req_valid[i]) begin
                    m_pend[i]  = 1'b1;
                    m_we[i]    = req_we[i];
                    m_f3[i]    = req_f3[i];
                    m_addr[i]  = req_addr[i];
                    m_wdata[i] = req_wdata[i];
                    m_left[i]  = wait_of(i);
                    if (m_left[i] == 0) model_exec(i);
                end
            end
        end
    end

    // Responses of the zero-wait instance during the back-to-back run
    bit          collecting = 1'b0;
    logic [31:0] resp_q1 [$];
    always @(negedge clk) begin
        if (collecting && rsp_valid[1]) resp_q1.push_back(rsp_rdata[1]);
    end

    // ---------------- directed drivers ----------------
    // Issue one request on instance i and wait (bounded) for its response
    task automatic do_req(input int i, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output bit er,
                          output int lat);
        bit acc = 1'b0;
        bit got = 1'b0;
        rd = 32'd0; er = 1'b0; lat = -1;
        req_we[i] = we; req_f3[i] = f3; req_addr[i] = addr; req_wdata[i] = wdata;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready[i];
            @(posedge clk);
        end
        #1 req_valid[i] = 1'b0;
        if (!acc) begin
            chk("accept timeout", 32'd0, 32'd1);
            return;
        end
        for (int n = 1; n <= 50 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1'b1; lat = n; rd = rsp_rdata[i]; er = rsp_err[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string nm, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd;
        bit          er;
        int          lat;
        do_req(0, we, f3, addr, wdata, rd, er, lat);
        $display("txn %s: rdata=0x%08h err=%0d latency=%0d", nm, rd, er, lat);
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " err"}, 32'(er), 32'(exp_err));
        chk({nm, " latency"}, lat, 3);
    endtask

    logic [31:0] b2b_vals [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};

    task automatic b2b_set(input int k);
        req_we[1]    = (k < 4);
        req_f3[1]    = 3'b010;
        req_addr[1]  = 32'(4 * (k % 4));
        req_wdata[1] = (k < 4) ? b2b_vals[k] : 32'h0;
    endtask

    initial begin
        bit          acc;
        int          k;
        int          acc_cyc [$];
        logic [31:0] a;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_f3[i] = 3'd0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", req_ready[0], 1);
        chk("reset valid", rsp_valid[0], 0);
        chk("reset rdata", rsp_rdata[0], 0);
        chk("reset err",   rsp_err[0],   0);
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        txn("SW 0x10",  1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0,         0);
        txn("LW 0x10",  0, 3'b010, 32'h10, 32'h0,         32'h8000_00F0, 0);
        txn("LB 0x13",  0, 3'b000, 32'h13, 32'h0,         32'hFFFF_FF80, 0);
        txn("LBU 0x13", 0, 3'b100, 32'h13, 32'h0,         32'h0000_0080, 0);
        txn("LH 0x12",  0, 3'b001, 32'h12, 32'h0,         32'hFFFF_8000, 0);
        txn("LHU 0x10", 0, 3'b101, 32'h10, 32'h0,         32'h0000_00F0, 0);
        txn("SB 0x11",  1, 3'b000, 32'h11, 32'hFFFF_FF5A, 32'h0,         0);
        txn("LW merge", 0, 3'b010, 32'h10, 32'h0,         32'h8000_5AF0, 0);
        txn("LW misal", 0, 3'b010, 32'h12, 32'h0,         32'h0,         1);
        txn("SH misal", 1, 3'b001, 32'h21, 32'hBEEF,      32'h0,         1);
        txn("LW 0x20",  0, 3'b010, 32'h20, 32'h0,         32'h0,         0);
        txn("LW top",   0, 3'b010, 32'(BYTES - 2), 32'h0, 32'h0,         1);
        txn("LD f3=3",  0, 3'b011, 32'h10, 32'h0,         32'h0,         1);
        txn("LW again", 0, 3'b010, 32'h10, 32'h0,         32'h8000_5AF0, 0);

        // Store accepted, then reset during its wait states
        req_we[0] = 1'b1; req_f3[0] = 3'b010; req_addr[0] = 32'h20; req_wdata[0] = 32'h1234_5678;
        req_valid[0] = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready[0];
            @(posedge clk);
        end
        #1 req_valid[0] = 1'b0;
        chk("abort accept", 32'(acc), 1);
        @(negedge clk);
        #2 rst[0] = 1'b0;
        #1;
        $display("txn abort: ready=%0d valid=%0d rdata=0x%08h err=%0d",
                 req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        chk("abort ready", req_ready[0], 1);
        chk("abort valid", rsp_valid[0], 0);
        chk("abort rdata", rsp_rdata[0], 0);
        chk("abort err",   rsp_err[0],   0);
        @(posedge clk);
        @(posedge clk);
        #1 rst[0] = 1'b1;
        txn("LW aborted", 0, 3'b010, 32'h20, 32'h0, 32'h0, 0);

        // Zero-wait instance with req_valid held high for 8 requests
        resp_q1.delete();
        collecting = 1'b1;
        k = 0;
        b2b_set(0);
        req_valid[1] = 1'b1;
        for (int n = 0; n < 60 && k < 8; n++) begin
            @(negedge clk);
            acc = req_ready[1];
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc.push_back(cyc);
                k++;
                if (k < 8) b2b_set(k);
                else req_valid[1] = 1'b0;
            end
        end
        repeat (4) @(posedge clk);
        #1 collecting = 1'b0;
        $display("txn b2b: accepts=%0d responses=%0d", k, resp_q1.size());
        chk("b2b accepts", k, 8);
        for (int j = 1; j < acc_cyc.size(); j++)
            chk($sformatf("b2b spacing %0d", j), acc_cyc[j] - acc_cyc[j-1], 2);
        chk("b2b responses", resp_q1.size(), 8);
        if (resp_q1.size() == 8) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("b2b store %0d rdata", j), resp_q1[j], 0);
                chk($sformatf("b2b load %0d rdata", j), resp_q1[4 + j], b2b_vals[j]);
            end
        end

        // Random traffic on both instances, including rare reset pulses
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                rst[i]       = ($urandom_range(0, 99) != 0);
                req_valid[i] = ($urandom_range(0, 2) != 0);
                req_we[i]    = 1'($urandom_range(0, 1));
                req_f3[i]    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                           : 3'($urandom_range(0, 2));
                case ($urandom_range(0, 7))
                    0:       a = $urandom | 32'h8000_0000;
                    1, 2:    a = 32'($urandom_range(BYTES - 8, BYTES + 3));
                    default: a = 32'($urandom_range(0, 31));
                endcase
                if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
                req_addr[i]  = a;
                req_wdata[i] = $urandom;
            end
        end
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            req_valid[i] = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter BYTES, default 256, meaning memory size in bytes (power of two, >= 4).
REQ-002 The block SHALL have parameter WAIT, default 2, meaning wait-state cycles inserted per access (0..15).
REQ-003 The block SHALL have port clk  input  1  meaning the single rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  meaning reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port req_valid  input  1  meaning a request is presented.
REQ-006 The block SHALL have port req_ready  output  1  meaning the controller can accept a request.
REQ-007 The block SHALL have port req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 The block SHALL have port req_f3  input  3  meaning RISC-V funct3 size/sign code.
REQ-009 The block SHALL have port req_addr  input  32  meaning byte address.
REQ-010 The block SHALL have port req_wdata  input  32  meaning store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid  output  1  meaning a one-cycle response strobe.
REQ-012 The block SHALL have port rsp_rdata  output  32  meaning load result, extended to 32 bits.
REQ-013 The block SHALL have port rsp_err  output  1  meaning the access faulted.

Function
REQ-014 Storage SHALL be BYTES x 8-bit, little-endian: byte at addr maps to bits [7:0].
REQ-015 The block SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, latching we, f3, addr and wdata.
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
  - req_ready=1 only in IDLE.
  - IDLE -> WAIT on accept when WAIT>0; IDLE -> RESP on accept when WAIT=0.
  - WAIT counts WAIT cycles, then -> RESP.
  - RESP lasts exactly one cycle, then -> IDLE.
REQ-017 rsp_valid SHALL be 1 only in RESP, i.e. WAIT+1 cycles after the accepting edge; maximum throughput is one access per WAIT+2 cycles.
REQ-018 Load codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - LB/LH sign-extend; LBU/LHU zero-extend.
REQ-019 Store codes: 000 SB, 001 SH, 010 SW; SB/SH SHALL write only 1/2 bytes and leave the other bytes unchanged.
REQ-020 An access SHALL fault (rsp_err=1) when any of the following holds:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr+size-1 >= BYTES;
  - funct3 is illegal for the direction.
REQ-021 A faulting access SHALL write nothing and return rsp_rdata=0.
REQ-022 A store SHALL commit to storage on the edge entering RESP; rsp_rdata SHALL be 0 for stores.
REQ-023 Load data SHALL be captured on the edge entering RESP. rsp_rdata SHALL hold its value until the next RESP entry or reset.
REQ-024 req_valid or request-field changes while req_ready=0 SHALL be ignored; no request is queued.
REQ-025 Storage SHALL initialise to all zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-026 While rst=0: state=IDLE, wait counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all asynchronously.
REQ-027 Reset asserted in WAIT SHALL abort the access; a store not yet committed SHALL NOT modify storage.
REQ-028 The first request SHALL be accepted on the first rising edge with rst=1 and req_valid=1.

Verification
REQ-029 WAIT=2: SW 0x8000_00F0 @0x10, then LW @0x10 -> rsp_valid on the 3rd cycle after each accept; LW returns 0x8000_00F0, err=0.
REQ-030 After REQ-029, LB @0x13 -> 0xFFFF_FF80; LBU @0x13 -> 0x0000_0080; LH @0x12 -> 0xFFFF_8000; LHU @0x10 -> 0x0000_00F0.
REQ-031 SB 0x5A @0x11, then LW @0x10 -> 0x8000_5AF0 (other bytes preserved).
REQ-032 Faults:
  - LW @0x12 -> err=1, rdata=0.
  - SH @0x21 -> err=1, memory unchanged.
  - LW @BYTES-2 -> err=1.
  - req_f3=011 load -> err=1.
REQ-033 SW 0x1234_5678 @0x20 accepted, rst pulled low in WAIT -> outputs zero immediately, req_ready=1; subsequent LW @0x20 -> 0x0000_0000.
REQ-034 WAIT=0 with req_valid held high: accepts every 2nd cycle, rsp_valid alternates 0/1, with no lost or duplicated responses across 8 requests.
